// File: rtl/stoplight_pkg.sv
// Shared stoplight codes, seven-segment patterns and phase defaults.
package stoplight_pkg;
  localparam logic [2:0] GREEN_RGB  = 3'b010;
  localparam logic [2:0] YELLOW_RGB = 3'b110;
  localparam logic [2:0] RED_RGB    = 3'b100;
  localparam logic [2:0] OFF_RGB    = 3'b000;

  localparam int GREEN_S_DEF  = 30;
  localparam int YELLOW_S_DEF = 3;
  localparam int RED_S_DEF    = 20;

  // Active-low, bit 6 = g ... bit 0 = a.
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_G     = 7'h42;
  localparam logic [6:0] SEG_Y     = 7'h11;
  localparam logic [6:0] SEG_R     = 7'h2F;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {B_IDLE, B_SHIFT, B_DONE} b2b_state_t;

  function automatic logic [6:0] seg_digit(input logic [3:0] d);
    case (d)
      4'd0: return SEG_0;
      4'd1: return SEG_1;
      4'd2: return SEG_2;
      4'd3: return SEG_3;
      4'd4: return SEG_4;
      4'd5: return SEG_5;
      4'd6: return SEG_6;
      4'd7: return SEG_7;
      4'd8: return SEG_8;
      4'd9: return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction

  function automatic logic light_valid(input logic [2:0] c);
    return (c == GREEN_RGB) || (c == YELLOW_RGB) || (c == RED_RGB);
  endfunction

  function automatic logic [6:0] letter_seg(input logic [2:0] c);
    case (c)
      GREEN_RGB:  return SEG_G;
      YELLOW_RGB: return SEG_Y;
      RED_RGB:    return SEG_R;
      default:    return SEG_BLANK;
    endcase
  endfunction
endpackage

// File: rtl/stoplight_countdown_display_bin2bcd_seq.sv
// 5-bit to two-digit BCD sequential double-dabble; starts that land while busy are queued.
module bin2bcd_seq
  import stoplight_pkg::*;
(
  input  logic       Clock,
  input  logic       Reset,
  input  logic       start,
  input  logic [4:0] bin_in,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       done,
  output logic       busy
);
  b2b_state_t state;
  logic [4:0] bin_q;
  logic [7:0] bcd;
  logic [7:0] adj;
  logic [2:0] cnt;
  logic       pend;

  always_comb begin
    adj = bcd;
    if (bcd[3:0] >= 4'd5) adj[3:0] = bcd[3:0] + 4'd3;
    if (bcd[7:4] >= 4'd5) adj[7:4] = bcd[7:4] + 4'd3;
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state <= B_IDLE;
      bin_q <= '0;
      bcd   <= '0;
      cnt   <= '0;
      pend  <= 1'b0;
      done  <= 1'b0;
      busy  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        B_IDLE: if (start || pend) begin
          // Load whatever is current now, so a queued request picks up the newest value.
          bin_q <= bin_in;
          bcd   <= '0;
          cnt   <= '0;
          pend  <= 1'b0;
          busy  <= 1'b1;
          state <= B_SHIFT;
        end
        B_SHIFT: begin
          {bcd, bin_q} <= {adj[6:0], bin_q, 1'b0};
          cnt <= cnt + 3'd1;
          if (start) pend <= 1'b1;
          if (cnt == 3'd4) begin
            state <= B_DONE;
            done  <= 1'b1;
          end
        end
        B_DONE: begin
          busy  <= 1'b0;
          state <= B_IDLE;
          if (start) pend <= 1'b1;
        end
        default: state <= B_IDLE;
      endcase
    end
  end

  assign tens = bcd[7:4];
  assign ones = bcd[3:0];
endmodule

// File: rtl/stoplight_countdown_display.sv
// Phase letter + seconds-remaining on the 8-digit seven-segment display.
// STOPLIGHT_BLINK_EN: blink the count digits at 2 Hz during yellow.
module stoplight_countdown_display
  import stoplight_pkg::*;
#(
  parameter int CLK_HZ   = 100_000_000,
  parameter int SCAN_HZ  = 1000,
  parameter int GREEN_S  = GREEN_S_DEF,
  parameter int YELLOW_S = YELLOW_S_DEF,
  parameter int RED_S    = RED_S_DEF
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [2:0] light_rgb,
  input  logic [4:0] elapsed,
  output logic [6:0] seg,
  output logic       dp,
  output logic [7:0] an
);
  localparam int DWELL = CLK_HZ / SCAN_HZ;
  localparam int DW    = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [4:0] G5 = 5'(GREEN_S);
  localparam logic [4:0] Y5 = 5'(YELLOW_S);
  localparam logic [4:0] R5 = 5'(RED_S);

  logic [2:0] light_s, light_p;
  logic [4:0] el_s, el_p;
  logic       init_pend;
  logic       start_req;
  logic [4:0] ph, rem;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      light_s   <= OFF_RGB;
      light_p   <= OFF_RGB;
      el_s      <= '0;
      el_p      <= '0;
      init_pend <= 1'b1;
    end else begin
      light_s <= light_rgb;
      el_s    <= elapsed;
      light_p <= light_s;
      el_p    <= el_s;
      if (start_req) init_pend <= 1'b0;
    end
  end

  assign start_req = light_valid(light_s) &&
                     ((light_s != light_p) || (el_s != el_p) || init_pend);

  always_comb begin
    ph = '0;
    case (light_s)
      GREEN_RGB:  ph = G5;
      YELLOW_RGB: ph = Y5;
      RED_RGB:    ph = R5;
      default:    ph = '0;
    endcase
    rem = (el_s > ph) ? 5'd0 : ph - el_s;
  end

  logic [3:0] cv_tens, cv_ones;
  logic       cv_done, cv_busy;

  bin2bcd_seq u_b2b (
    .Clock  (Clock),
    .Reset  (Reset),
    .start  (start_req),
    .bin_in (rem),
    .tens   (cv_tens),
    .ones   (cv_ones),
    .done   (cv_done),
    .busy   (cv_busy)
  );

  // Display register: only moves on conversion done, so the digits never glitch mid-conversion.
  logic       disp_valid;
  logic [3:0] disp_tens, disp_ones;
  logic [6:0] disp_letter;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      disp_valid  <= 1'b0;
      disp_tens   <= '0;
      disp_ones   <= '0;
      disp_letter <= SEG_BLANK;
    end else if (cv_done) begin
      disp_valid  <= 1'b1;
      disp_tens   <= cv_tens;
      disp_ones   <= cv_ones;
      disp_letter <= letter_seg(light_s);
    end
  end

  logic digits_on;
`ifdef STOPLIGHT_BLINK_EN
  localparam int HALF = CLK_HZ / 4;
  localparam int BW   = (HALF > 1) ? $clog2(HALF) : 1;
  logic [BW-1:0] blink_cnt;
  logic          blink_on;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      blink_cnt <= '0;
      blink_on  <= 1'b1;
    end else if (light_s == YELLOW_RGB && light_p != YELLOW_RGB) begin
      blink_cnt <= '0;
      blink_on  <= 1'b1;
    end else if (blink_cnt == BW'(HALF - 1)) begin
      blink_cnt <= '0;
      blink_on  <= ~blink_on;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  assign digits_on = (light_s != YELLOW_RGB) || blink_on;
`else
  assign digits_on = 1'b1;
`endif

  logic [DW-1:0] dwell;
  logic [2:0]    slot;
  logic [6:0]    seg_nxt;
  logic [7:0]    an_nxt;
  logic          show;

  assign show = disp_valid && light_valid(light_s);

  always_comb begin
    seg_nxt = SEG_BLANK;
    an_nxt  = 8'hFF;
    if (show) begin
      case (slot)
        3'd0: if (digits_on) begin
          seg_nxt = seg_digit(disp_ones);
          an_nxt  = 8'hFE;
        end
        3'd1: if (digits_on && disp_tens != 4'd0) begin
          seg_nxt = seg_digit(disp_tens);
          an_nxt  = 8'hFD;
        end
        3'd7: begin
          seg_nxt = disp_letter;
          an_nxt  = 8'h7F;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      dwell <= '0;
      slot  <= '0;
      seg   <= SEG_BLANK;
      an    <= 8'hFF;
    end else begin
      if (dwell == DW'(DWELL - 1)) begin
        dwell <= '0;
        slot  <= slot + 3'd1;
      end else begin
        dwell <= dwell + 1'b1;
      end
      seg <= seg_nxt;
      an  <= an_nxt;
    end
  end

  assign dp = 1'b1;
endmodule

// File: tb/tb_stoplight_countdown_display.sv
// Directed vector bench for the countdown display at 8 clocks per digit slot.
module tb_stoplight_countdown_display;
  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic [2:0] light_rgb = 3'b000;
  logic [4:0] elapsed = 5'd0;
  logic [6:0] seg;
  logic       dp;
  logic [7:0] an;

  int ncmp = 0;
  int nerr = 0;

  stoplight_countdown_display #(
    .CLK_HZ  (800),
    .SCAN_HZ (100)
  ) dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .light_rgb (light_rgb),
    .elapsed   (elapsed),
    .seg       (seg),
    .dp        (dp),
    .an        (an)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic [2:0] light;
    logic [4:0] el;
    logic [7:0] e0;  // {unlit, seg}: 8'hFF means the slot never lights
    logic [7:0] e1;
    logic [7:0] e7;
  } vec_t;

  vec_t vt[16];
  logic [7:0] obs[8];
  logic [4:0] others;
  logic       badfr;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic scan();
    for (int i = 0; i < 8; i++) obs[i] = 8'hFF;
    others = '0;
    badfr  = 1'b0;
    repeat (64) begin
      @(negedge Clock);
      if (dp !== 1'b1 || $countones(~an) > 1) badfr = 1'b1;
      for (int i = 0; i < 8; i++)
        if (an[i] === 1'b0) begin
          obs[i] = {1'b0, seg};
          if (i >= 2 && i <= 6) others[i-2] = 1'b1;
        end
    end
  endtask

  task automatic check_disp(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                            input logic [7:0] e7);
    scan();
    chk({tag, " slot0"}, {24'd0, obs[0]}, {24'd0, e0});
    chk({tag, " slot1"}, {24'd0, obs[1]}, {24'd0, e1});
    chk({tag, " slot7"}, {24'd0, obs[7]}, {24'd0, e7});
    chk({tag, " slots2-6"}, {27'd0, others}, 32'd0);
    chk({tag, " frame"}, {31'd0, badfr}, 32'd0);
  endtask

  initial begin
    logic blank_hold;
    vt[0]  = '{3'b010, 5'd0,  8'h40, 8'h30, 8'h42};  // 30
    vt[1]  = '{3'b110, 5'd2,  8'h79, 8'hFF, 8'h11};  // 1
    vt[2]  = '{3'b100, 5'd25, 8'h40, 8'hFF, 8'h2F};  // saturate
    vt[3]  = '{3'b010, 5'd17, 8'h30, 8'h79, 8'h42};  // 13
    vt[4]  = '{3'b100, 5'd9,  8'h79, 8'h79, 8'h2F};  // 11
    vt[5]  = '{3'b100, 5'd31, 8'h40, 8'hFF, 8'h2F};  // saturate
    vt[6]  = '{3'b010, 5'd6,  8'h19, 8'h24, 8'h42};  // 24
    vt[7]  = '{3'b110, 5'd3,  8'h40, 8'hFF, 8'h11};  // 0 exactly
    vt[8]  = '{3'b000, 5'd5,  8'hFF, 8'hFF, 8'hFF};  // off
    vt[9]  = '{3'b111, 5'd0,  8'hFF, 8'hFF, 8'hFF};  // undefined code
    vt[10] = '{3'b010, 5'd22, 8'h00, 8'hFF, 8'h42};  // 8
    vt[11] = '{3'b100, 5'd2,  8'h00, 8'h79, 8'h2F};  // 18
    vt[12] = '{3'b010, 5'd3,  8'h78, 8'h24, 8'h42};  // 27
    vt[13] = '{3'b100, 5'd5,  8'h12, 8'h79, 8'h2F};  // 15
    vt[14] = '{3'b100, 5'd11, 8'h10, 8'hFF, 8'h2F};  // 9
    vt[15] = '{3'b010, 5'd24, 8'h02, 8'hFF, 8'h42};  // 6

    @(posedge Clock);
    repeat (3) begin
      @(negedge Clock);
      chk("reset outputs", {16'd0, seg, an, dp}, {16'd0, 7'h7F, 8'hFF, 1'b1});
    end
    Reset = 1'b0;

    for (int v = 0; v < 16; v++) begin
      light_rgb = vt[v].light;
      elapsed   = vt[v].el;
      repeat (12) @(negedge Clock);
      check_disp($sformatf("v%0d", v), vt[v].e0, vt[v].e1, vt[v].e7);
    end

    // Back-to-back changes: the second lands during SHIFT and must win.
    @(negedge Clock);
    light_rgb = 3'b010;
    elapsed   = 5'd10;
    @(negedge Clock);
    elapsed   = 5'd20;
    repeat (16) @(negedge Clock);
    check_disp("last-wins", 8'h40, 8'h79, 8'h42);

    // Reset in the middle of a conversion.
    light_rgb = 3'b100;
    elapsed   = 5'd0;
    repeat (3) @(negedge Clock);
    Reset = 1'b1;
    @(negedge Clock);
    chk("mid-shift reset", {16'd0, seg, an, dp}, {16'd0, 7'h7F, 8'hFF, 1'b1});
    Reset = 1'b0;
    blank_hold = 1'b1;
    repeat (7) begin
      @(negedge Clock);
      if (an !== 8'hFF) blank_hold = 1'b0;
    end
    chk("blank until reconvert", {31'd0, blank_hold}, 32'd1);
    repeat (5) @(negedge Clock);
    check_disp("post-reset", 8'h40, 8'h24, 8'h2F);

    $display("== %0d vectors applied, %0d miscompares ==", ncmp, nerr);
    $finish;
  end
endmodule
